// File: rtl/huff_pkg.sv
// Shared types and width helpers for the parametrised Huffman encoder.
// The WGT_W/LEN_W constants describe the default three-symbol, 3-bit-frequency build.
package huff_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        MERGE  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int len_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Wide enough that the sum of all n frequencies never overflows.
    function automatic int wgt_w(input int fw, input int n);
        return fw + $clog2(n);
    endfunction

    localparam int WGT_W = wgt_w(3, 3);
    localparam int LEN_W = len_w(3);

endpackage

// File: rtl/huff_encoder_param_min2.sv
// Combinational search for the two lightest active nodes; ties resolve to the lowest index.
module huff_min2 #(
    parameter int NUM_SYM = 3,
    parameter int WGT_W   = huff_pkg::WGT_W
) (
    input  logic [WGT_W-1:0]           wgt [NUM_SYM],
    input  logic [NUM_SYM-1:0]         act,
    output logic [$clog2(NUM_SYM)-1:0] m1,
    output logic [$clog2(NUM_SYM)-1:0] m2,
    output logic                       valid
);
    localparam int IW = $clog2(NUM_SYM);

    logic             f1, f2;
    logic [WGT_W-1:0] b1, b2;

    always_comb begin
        f1 = 1'b0;
        f2 = 1'b0;
        b1 = '0;
        b2 = '0;
        m1 = '0;
        m2 = '0;
        // Strict less-than keeps the first (lowest) index among equal weights.
        for (int i = 0; i < NUM_SYM; i++) begin
            if (act[i] && (!f1 || wgt[i] < b1)) begin
                f1 = 1'b1;
                b1 = wgt[i];
                m1 = IW'(i);
            end
        end
        for (int i = 0; i < NUM_SYM; i++) begin
            if (act[i] && IW'(i) != m1 && (!f2 || wgt[i] < b2)) begin
                f2 = 1'b1;
                b2 = wgt[i];
                m2 = IW'(i);
            end
        end
        valid = f1 && f2;
    end

endmodule

// File: rtl/huff_encoder_param.sv
// Huffman code builder: load NUM_SYM pairs, merge two minima per cycle, stream codes in load order.
// Optional HUFF_ZERO_SKIP_EN excludes zero-frequency symbols from the tree.
module huff_encoder_param
    import huff_pkg::*;
#(
    parameter int NUM_SYM = 3,
    parameter int FREQ_W  = 3,
    parameter int SYM_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    // Both ports: a transfer happens on a rising edge where valid && ready;
    // valid must hold its data until that edge.
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W-1:0]         in_sym,
    input  logic [FREQ_W-1:0]        in_freq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYM_W-1:0]         out_sym,
    output logic [NUM_SYM-2:0]       out_code,
    output logic [$clog2(NUM_SYM):0] out_len,
    output logic                     done,
    output logic [1:0]               dbg_state
);
    localparam int WW = wgt_w(FREQ_W, NUM_SYM);
    localparam int LW = len_w(NUM_SYM);
    localparam int IW = idx_w(NUM_SYM);
    localparam int CW = NUM_SYM - 1;

    state_t           state;
    logic [IW-1:0]    cnt;  // load index, merge count or output index, by state
    logic [SYM_W-1:0] sym_r   [NUM_SYM];
    logic [WW-1:0]    wgt     [NUM_SYM];
    logic [WW-1:0]    wgt_nx  [NUM_SYM];
    logic [IW-1:0]    grp     [NUM_SYM];
    logic [IW-1:0]    grp_nx  [NUM_SYM];
    logic [CW-1:0]    code    [NUM_SYM];
    logic [CW-1:0]    code_nx [NUM_SYM];
    logic [LW-1:0]    len     [NUM_SYM];
    logic [LW-1:0]    len_nx  [NUM_SYM];
    logic [NUM_SYM-1:0] act, act_nx;
    logic [IW-1:0]    m1, m2, sel;
    logic [LW-1:0]    sel_len;
    logic             pair_ok;

    assign dbg_state = state;

    huff_min2 #(.NUM_SYM(NUM_SYM), .WGT_W(WW)) u_min2 (
        .wgt   (wgt),
        .act   (act),
        .m1    (m1),
        .m2    (m2),
        .valid (pair_ok)
    );

    // Codes grow from the leaf upward, so each merge writes the next-higher bit.
    always_comb begin
        wgt_nx  = wgt;
        grp_nx  = grp;
        act_nx  = act;
        code_nx = code;
        len_nx  = len;
        if (state == MERGE && pair_ok) begin
            for (int s = 0; s < NUM_SYM; s++) begin
                if (grp[s] == m1) begin
                    len_nx[s] = len[s] + LW'(1);
                end else if (grp[s] == m2) begin
                    code_nx[s] = code[s] | (CW'(1) << len[s]);
                    len_nx[s]  = len[s] + LW'(1);
                    grp_nx[s]  = m1;
                end
            end
            wgt_nx[m1] = wgt[m1] + wgt[m2];
            act_nx[m2] = 1'b0;
        end
    end

    always_comb begin
        sel = '0;
        if (state == OUTPUT && cnt != IW'(NUM_SYM-1))
            sel = cnt + IW'(1);
        sel_len = len_nx[sel];
`ifdef HUFF_ZERO_SKIP_EN
        // A lone live symbol never merges; it still needs a one-bit code.
        if (len_nx[sel] == '0 && wgt[sel] != '0)
            sel_len = LW'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_sym   <= '0;
            out_code  <= '0;
            out_len   <= '0;
            act       <= '0;
            for (int s = 0; s < NUM_SYM; s++) begin
                sym_r[s] <= '0;
                wgt[s]   <= '0;
                grp[s]   <= '0;
                code[s]  <= '0;
                len[s]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        sym_r[cnt] <= in_sym;
                        wgt[cnt]   <= WW'(in_freq);
                        grp[cnt]   <= cnt;
                        code[cnt]  <= '0;
                        len[cnt]   <= '0;
`ifdef HUFF_ZERO_SKIP_EN
                        act[cnt]   <= (in_freq != '0);
`else
                        act[cnt]   <= 1'b1;
`endif
                        if (cnt == IW'(NUM_SYM-1)) begin
                            state    <= MERGE;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + IW'(1);
                        end
                    end
                end
                MERGE: begin
                    wgt  <= wgt_nx;
                    grp  <= grp_nx;
                    act  <= act_nx;
                    code <= code_nx;
                    len  <= len_nx;
                    if (cnt == IW'(NUM_SYM-2)) begin
                        state     <= OUTPUT;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_sym   <= sym_r[sel];
                        out_code  <= code_nx[sel];
                        out_len   <= sel_len;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_valid && out_ready) begin
                        if (cnt == IW'(NUM_SYM-1)) begin
                            state     <= LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt      <= sel;
                            out_sym  <= sym_r[sel];
                            out_code <= code_nx[sel];
                            out_len  <= sel_len;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
